// File: rtl/uart_pkg.sv
// Shared UART definitions, used by both the transmit and receive paths.
//   uart_state  : frame-level state encoding common to uart_tx and uart_rx
//   PARITY_*    : legal values of the PARITY_BIT parameter
package uart_pkg;

   typedef enum logic [2:0] {
      UART_IDLE,
      UART_START,
      UART_DATA,
      UART_PARITY,
      UART_STOP
   } uart_state;

   localparam string PARITY_NONE = "none";
   localparam string PARITY_EVEN = "even";
   localparam string PARITY_ODD  = "odd";

endpackage

// File: rtl/parity.sv
// Parity generator.
//   data : word to protect (BITS wide)
//   par  : odd-parity bit, i.e. the bit that makes {data, par} contain an
//          odd number of ones
module parity #(
   parameter int BITS = 8
) (
   input  logic [BITS-1:0] data,
   output logic            par
);

   assign par = ~(^data);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers asynchronous serial frames from rx and presents
// each word on a valid/ready handshake with error status.
//   clk        : logic clock
//   rst        : synchronous, active-low reset
//   rx         : asynchronous serial line, idles high
//   rx_data    : received word, stable while rx_valid is high
//   rx_valid   : word available
//   rx_ready   : consumer accepts; transfer when rx_valid && rx_ready
//   parity_err : parity mismatch for the held word (qualified by rx_valid)
//   frame_err  : a stop bit was sampled low for the held word
//   overrun    : one-cycle pulse when a frame completes while the previous
//                word is still unaccepted (the new frame is dropped)
//   busy       : receiver is inside a frame
module uart_rx
   import uart_pkg::*;
#(
   parameter int    DATA_BITS    = 8,
   parameter string PARITY_BIT   = "none",
   parameter int    STOP_BITS    = 1,
   parameter int    UART_CLK_DIV = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int H        = UART_CLK_DIV / 2;
   localparam int CNT_W    = $clog2(UART_CLK_DIV);
   localparam int IDX_W    = $clog2(DATA_BITS);
   localparam bit PAR_EVEN = (PARITY_BIT == PARITY_EVEN);
   localparam bit PAR_EN   = PAR_EVEN || (PARITY_BIT == PARITY_ODD);

   // Two-flop synchroniser plus one delay stage for falling-edge detection.
   // All three reset high so a reset never looks like a start bit.
   logic sync_q;
   logic rx_s;
   logic rx_s_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q <= 1'b1;
         rx_s   <= 1'b1;
         rx_s_d <= 1'b1;
      end else begin
         sync_q <= rx;
         rx_s   <= sync_q;
         rx_s_d <= rx_s;
      end
   end

   uart_state            state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [IDX_W-1:0]     idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_err_q;
   logic                 frm_err_q;
   logic                 odd_bit;
   logic                 exp_par;
   logic                 bit_tick;
   logic                 half_tick;
   logic                 stop_last;

   parity #(
      .BITS (DATA_BITS)
   ) u_parity (
      .data (shreg),
      .par  (odd_bit)
   );

   // Even parity expects the plain XOR of the data, odd expects its inverse.
   assign exp_par   = PAR_EVEN ? ~odd_bit : odd_bit;
   assign bit_tick  = (bit_cnt == CNT_W'(UART_CLK_DIV - 1));
   assign half_tick = (bit_cnt == CNT_W'(H - 1));
   assign stop_last = (stop_idx == 1'(STOP_BITS - 1));

   // NOTE: the shift register carries no reset; every bit is rewritten in
   // UART_DATA before parity or delivery ever looks at it.
   always_ff @(posedge clk) begin
      if (state == UART_DATA && bit_tick) begin
         shreg[idx] <= rx_s;
      end
   end

   // NOTE: later non-blocking assignments in this block override earlier
   // ones, so a delivery in UART_STOP wins over the accept-clear of rx_valid
   // and over the default-low of overrun.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= UART_IDLE;
         busy       <= 1'b0;
         bit_cnt    <= '0;
         idx        <= '0;
         stop_idx   <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         bit_cnt <= bit_tick ? '0 : bit_cnt + 1'b1;

         case (state)
            UART_IDLE: begin
               bit_cnt <= '0;
               if (rx_s_d && !rx_s) begin
                  state <= UART_START;
                  busy  <= 1'b1;
               end
            end

            // Half a bit into the start bit: a line already back high was
            // a glitch, otherwise re-phase the counter to mid-bit.
            UART_START: begin
               if (half_tick) begin
                  if (rx_s) begin
                     state <= UART_IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state     <= UART_DATA;
                     idx       <= '0;
                     bit_cnt   <= '0;
                     par_err_q <= 1'b0;
                     frm_err_q <= 1'b0;
                  end
               end
            end

            UART_DATA: begin
               if (bit_tick) begin
                  idx <= idx + 1'b1;
                  if (idx == IDX_W'(DATA_BITS - 1)) begin
                     stop_idx <= 1'b0;
                     state    <= PAR_EN ? UART_PARITY : UART_STOP;
                  end
               end
            end

            UART_PARITY: begin
               if (bit_tick) begin
                  par_err_q <= (rx_s != exp_par);
                  state     <= UART_STOP;
               end
            end

            // Leave at mid-stop-bit so a back-to-back start edge is caught.
            UART_STOP: begin
               if (bit_tick) begin
                  if (!stop_last) begin
                     frm_err_q <= frm_err_q | ~rx_s;
                     stop_idx  <= 1'b1;
                  end else begin
                     state <= UART_IDLE;
                     busy  <= 1'b0;
                     if (!rx_valid || rx_ready) begin
                        rx_data    <= shreg;
                        parity_err <= par_err_q;
                        frame_err  <= frm_err_q | ~rx_s;
                        rx_valid   <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
               end
            end

            default: begin
               state <= UART_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. Three receivers (8N1, 8E1, 8N2, all DIV=10)
// each have their own serial line; a negedge monitor records handshake
// transfers, valid rise times, overrun pulses and busy activity.
module tb_uart_rx;

   localparam int DIV = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] rx_line = '1;
   logic [2:0] ready   = '1;

   logic [7:0] data  [3];
   logic       valid [3];
   logic       perr  [3];
   logic       ferr  [3];
   logic       ovr   [3];
   logic       busy  [3];

   int cyc      = 0;
   int checks   = 0;
   int failures = 0;

   int         rise_cyc  [3] = '{default: 0};
   int         hi_cnt    [3] = '{default: 0};
   int         xfer_cnt  [3] = '{default: 0};
   int         ovr_cnt   [3] = '{default: 0};
   int         ovr_cyc   [3] = '{default: 0};
   int         busy_hi   [3] = '{default: 0};
   int         busy_rise [3] = '{default: 0};
   int         busy_fall [3] = '{default: 0};
   logic [7:0] xfer_data [3] = '{default: 8'h00};
   logic       xfer_perr [3] = '{default: 1'b0};
   logic       xfer_ferr [3] = '{default: 1'b0};
   logic       valid_q   [3] = '{default: 1'b0};
   logic       busy_q    [3] = '{default: 1'b0};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.DATA_BITS(8), .PARITY_BIT("none"), .STOP_BITS(1), .UART_CLK_DIV(DIV)) u_n1 (
      .clk(clk), .rst(rst), .rx(rx_line[0]), .rx_data(data[0]), .rx_valid(valid[0]),
      .rx_ready(ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]),
      .busy(busy[0]));

   uart_rx #(.DATA_BITS(8), .PARITY_BIT("even"), .STOP_BITS(1), .UART_CLK_DIV(DIV)) u_e1 (
      .clk(clk), .rst(rst), .rx(rx_line[1]), .rx_data(data[1]), .rx_valid(valid[1]),
      .rx_ready(ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]),
      .busy(busy[1]));

   uart_rx #(.DATA_BITS(8), .PARITY_BIT("none"), .STOP_BITS(2), .UART_CLK_DIV(DIV)) u_n2 (
      .clk(clk), .rst(rst), .rx(rx_line[2]), .rx_data(data[2]), .rx_valid(valid[2]),
      .rx_ready(ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]),
      .busy(busy[2]));

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (valid[i] && !valid_q[i]) rise_cyc[i] <= cyc;
         if (valid[i]) hi_cnt[i] <= hi_cnt[i] + 1;
         if (valid[i] && ready[i]) begin
            xfer_cnt[i]  <= xfer_cnt[i] + 1;
            xfer_data[i] <= data[i];
            xfer_perr[i] <= perr[i];
            xfer_ferr[i] <= ferr[i];
         end
         if (ovr[i]) begin
            ovr_cnt[i] <= ovr_cnt[i] + 1;
            ovr_cyc[i] <= cyc;
         end
         if (busy[i]) begin
            busy_hi[i] <= busy_hi[i] + 1;
            if (!busy_q[i]) busy_rise[i] <= cyc;
         end else if (busy_q[i]) begin
            busy_fall[i] <= cyc;
         end
         valid_q[i] <= valid[i];
         busy_q[i]  <= busy[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives n line bits (bit 0 first) for DIV clocks each, starting just
   // after a posedge; c0 is the cycle count of that posedge. The line is
   // left at the last bit value.
   task automatic send(input int ch, input logic [31:0] bits, input int n, output int c0);
      @(posedge clk);
      #1;
      c0 = cyc;
      for (int i = 0; i < n; i++) begin
         rx_line[ch] = bits[i];
         repeat (DIV) @(posedge clk);
         #1;
      end
   endtask

   int c0, n0, h0, o0, b0;

   initial begin
      // Reset state
      idle(3);
      @(negedge clk);
      check("rst_valid", 32'(valid[0]), 0);
      check("rst_data",  32'(data[0]),  0);
      check("rst_perr",  32'(perr[1]),  0);
      check("rst_ferr",  32'(ferr[2]),  0);
      check("rst_ovr",   32'(ovr[0]),   0);
      check("rst_busy",  32'(busy[0]),  0);
      idle(1);
      rst = 1'b1;
      idle(5);

      // 8N1 0xA5, ready high: one-cycle valid at fall + 3 + 5 + 90
      n0 = xfer_cnt[0];
      h0 = hi_cnt[0];
      send(0, 32'({1'b1, 8'hA5, 1'b0}), 10, c0);
      rx_line[0] = 1'b1;
      idle(5);
      check("a5_xfer", 32'(xfer_cnt[0] - n0), 1);
      check("a5_data", 32'(xfer_data[0]), 32'hA5);
      check("a5_perr", 32'(xfer_perr[0]), 0);
      check("a5_ferr", 32'(xfer_ferr[0]), 0);
      check("a5_time", 32'(rise_cyc[0] - c0), 98);
      check("a5_width", 32'(hi_cnt[0] - h0), 1);

      // 8E1: 0x03 has XOR 0, so parity bit 1 is wrong, 0 is right
      send(1, 32'({1'b1, 1'b1, 8'h03, 1'b0}), 11, c0);
      rx_line[1] = 1'b1;
      idle(5);
      check("e1_bad_data", 32'(xfer_data[1]), 32'h03);
      check("e1_bad_perr", 32'(xfer_perr[1]), 1);
      check("e1_bad_ferr", 32'(xfer_ferr[1]), 0);
      check("e1_time", 32'(rise_cyc[1] - c0), 108);
      send(1, 32'({1'b1, 1'b0, 8'h03, 1'b0}), 11, c0);
      rx_line[1] = 1'b1;
      idle(5);
      check("e1_good_data", 32'(xfer_data[1]), 32'h03);
      check("e1_good_perr", 32'(xfer_perr[1]), 0);
      // 0x07 has XOR 1, so parity bit 1 is right
      send(1, 32'({1'b1, 1'b1, 8'h07, 1'b0}), 11, c0);
      rx_line[1] = 1'b1;
      idle(5);
      check("e1_07_data", 32'(xfer_data[1]), 32'h07);
      check("e1_07_perr", 32'(xfer_perr[1]), 0);

      // 8N2 with the second stop bit low, then a 30-cycle low hold
      send(2, 32'({1'b0, 1'b1, 8'h3C, 1'b0}), 11, c0);
      idle(2);
      check("n2_data", 32'(xfer_data[2]), 32'h3C);
      check("n2_ferr", 32'(xfer_ferr[2]), 1);
      check("n2_time", 32'(rise_cyc[2] - c0), 108);
      n0 = xfer_cnt[2];
      b0 = busy_hi[2];
      idle(30);
      rx_line[2] = 1'b1;
      idle(150);
      check("n2_hold_xfer", 32'(xfer_cnt[2] - n0), 0);
      check("n2_hold_busy", 32'(busy_hi[2] - b0), 0);
      send(2, 32'({1'b1, 1'b1, 8'hC3, 1'b0}), 11, c0);
      idle(2);
      check("n2_rearm_xfer", 32'(xfer_cnt[2] - n0), 1);
      check("n2_rearm_data", 32'(xfer_data[2]), 32'hC3);
      check("n2_rearm_ferr", 32'(xfer_ferr[2]), 0);

      // 3-cycle low glitch: busy for 5 cycles, no word
      n0 = xfer_cnt[0];
      h0 = hi_cnt[0];
      b0 = busy_hi[0];
      @(posedge clk);
      #1;
      c0 = cyc;
      rx_line[0] = 1'b0;
      idle(3);
      rx_line[0] = 1'b1;
      idle(30);
      check("glitch_busy_rise", 32'(busy_rise[0] - c0), 3);
      check("glitch_busy_fall", 32'(busy_fall[0] - c0), 8);
      check("glitch_busy_len",  32'(busy_hi[0] - b0), 5);
      check("glitch_valid",     32'(hi_cnt[0] - h0), 0);
      check("glitch_xfer",      32'(xfer_cnt[0] - n0), 0);

      // Back-to-back 0x11, 0x22 with ready low: second frame overruns
      ready[0] = 1'b0;
      n0 = xfer_cnt[0];
      o0 = ovr_cnt[0];
      send(0, 32'({1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0}), 20, c0);
      rx_line[0] = 1'b1;
      idle(3);
      check("ovr_rise",  32'(rise_cyc[0] - c0), 98);
      check("ovr_count", 32'(ovr_cnt[0] - o0), 1);
      check("ovr_time",  32'(ovr_cyc[0] - c0), 198);
      check("ovr_held",  32'(data[0]), 32'h11);
      check("ovr_valid", 32'(valid[0]), 1);
      check("ovr_noxfer", 32'(xfer_cnt[0] - n0), 0);
      ready[0] = 1'b1;
      idle(3);
      check("ovr_xfer",  32'(xfer_cnt[0] - n0), 1);
      check("ovr_xdata", 32'(xfer_data[0]), 32'h11);
      check("ovr_clear", 32'(valid[0]), 0);

      // Reset mid-DATA while a word is held, then a clean 0x5A
      ready[0] = 1'b0;
      send(0, 32'({1'b1, 8'h77, 1'b0}), 10, c0);
      rx_line[0] = 1'b1;
      idle(3);
      check("pre_rst_valid", 32'(valid[0]), 1);
      rx_line[0] = 1'b0;
      idle(30);
      check("pre_rst_busy", 32'(busy[0]), 1);
      rst = 1'b0;
      rx_line[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_valid", 32'(valid[0]), 0);
      check("mid_rst_data",  32'(data[0]),  0);
      check("mid_rst_busy",  32'(busy[0]),  0);
      check("mid_rst_ovr",   32'(ovr[0]),   0);
      check("mid_rst_ferr",  32'(ferr[0]),  0);
      idle(2);
      rst = 1'b1;
      ready[0] = 1'b1;
      n0 = xfer_cnt[0];
      idle(20);
      check("post_rst_busy", 32'(busy[0]), 0);
      check("post_rst_xfer", 32'(xfer_cnt[0] - n0), 0);
      send(0, 32'({1'b1, 8'h5A, 1'b0}), 10, c0);
      rx_line[0] = 1'b1;
      idle(5);
      check("5a_xfer", 32'(xfer_cnt[0] - n0), 1);
      check("5a_data", 32'(xfer_data[0]), 32'h5A);
      check("5a_ferr", 32'(xfer_ferr[0]), 0);
      check("5a_time", 32'(rise_cyc[0] - c0), 98);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive-side counterpart to `uart_tx`. It recovers asynchronous serial frames from the `rx` line and presents each received word on a valid/ready handshake, with parity-error, framing-error and overrun status. It sits directly downstream of the UART pin, or of `uart_tx` in loopback, and feeds the UPDI response-parsing logic. Frame format and bit period are parameterised identically to `uart_tx`, so one parameter set configures both directions.

## Interface
- `DATA_BITS`, 8, data bits per frame, 5–9, LSB first
- `PARITY_BIT`, "none", one of "none", "even", "odd"
- `STOP_BITS`, 1, stop bits checked, 1–2
- `UART_CLK_DIV`, 10, `clk` cycles per bit period, ≥4, same meaning as in `uart_tx`

Ports (name, direction, width, meaning):
- `clk` input 1: logic clock
- `rst` input 1: synchronous, active-low; reset is applied on a `clk` edge while `rst`=0
- `rx` input 1: asynchronous serial line, idles high
- `rx_data` output DATA_BITS: received word, stable while `rx_valid`=1
- `rx_valid` output 1: word available
- `rx_ready` input 1: consumer accepts; transfer occurs when `rx_valid`=1 and `rx_ready`=1
- `parity_err` output 1: parity mismatch for the held word, qualified by `rx_valid`
- `frame_err` output 1: a stop bit was sampled low for the held word, qualified by `rx_valid`
- `overrun` output 1: one-cycle pulse when a frame completes while the previous word is unaccepted
- `busy` output 1: high when the state is not `UART_IDLE`

## Operation
- Reset values: `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `overrun`=0, `busy`=0. Both synchroniser flops reset to 1. State resets to `UART_IDLE`.
- **Input path:** `rx` passes through a 2-flop synchroniser to give `rx_s`. A registered `rx_s_d` drives fall detection.
- **Bit timing:** a free-running-while-busy counter `bit_cnt` counts 0..UART_CLK_DIV-1. Define H = UART_CLK_DIV/2 (floor).
- **State machine** (`uart_state`):
  - `UART_IDLE`: on `rx_s_d`=1 and `rx_s`=0, load `bit_cnt`=0 and go to `UART_START`.
  - `UART_START`: when `bit_cnt`=H-1, sample `rx_s`.
    - If 1, this is a false start: return to IDLE with no output.
    - If 0, clear the shift index and `bit_cnt`, then go to `UART_DATA`.
  - `UART_DATA`: each time `bit_cnt` wraps to UART_CLK_DIV-1, shift `rx_s` in at index `idx` (LSB first). After index DATA_BITS-1, go to `UART_PARITY` if parity is enabled, otherwise to `UART_STOP`.
  - `UART_PARITY`: take one sample and record the mismatch against the parity computed over the shifted data. For "even", the expected bit is the XOR of the data; for "odd", it is its complement. Then go to `UART_STOP`.
  - `UART_STOP`: take STOP_BITS samples. Any 0 sets the frame error. After the last sample, deliver the frame and go to IDLE immediately, at mid-stop-bit. This allows back-to-back frames.
- **Delivery:**
  - If `rx_valid`=0, or if `rx_ready`=1 in the same cycle, load `rx_data`, `parity_err` and `frame_err`, and set `rx_valid`=1.
  - Otherwise drop the new frame, keep the held word, and pulse `overrun`.
- **Accept:** `rx_valid` clears on the cycle after a transfer unless a delivery coincides. A coincident delivery wins, so `rx_valid` stays 1 with the new data.
- A frame ending in a low stop bit (including a break) does not re-arm until `rx_s` has returned high, because detection is edge-based.
- Reset during a frame aborts it immediately. No partial output is produced.

## Timing
- Let E be the cycle the fall is detected. E is 2–3 cycles after `rx` falls, due to the synchroniser and edge detection.
- The start bit is sampled at E+H, and bit k (k≥1) at E+H+k·UART_CLK_DIV.
- Let N = DATA_BITS + (parity ? 1 : 0) + STOP_BITS. `rx_valid` rises at E+H+N·UART_CLK_DIV+1.
- `overrun` is a 1-cycle pulse in that same cycle.
- The earliest next-start detection is the cycle after the return to IDLE.

## Structure
- Shared package `uart_pkg` holds:
  - the `uart_state` enum (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_PARITY`, `UART_STOP`), shared with `uart_tx`;
  - the parity-mode string constants.
- Sub-module: instantiate the existing `parity` block (BITS=DATA_BITS) on the shift register. Its output is the odd-parity bit.
- The bit counter is local and does not use `clock_divider`, because reception needs a half-bit phase alignment that `clock_divider` does not provide.

## Test plan
- **8N1, DIV=10, frame 0xA5, `rx_ready`=1:** expect `rx_valid` for 1 cycle with `rx_data`=0xA5, no errors, at E+5+90+1.
- **8E1, frame 0x03 with parity bit 1 (wrong):** expect `parity_err`=1 with `rx_data`=0x03. Repeat with parity bit 0: expect `parity_err`=0.
- **8N2, second stop bit driven 0:** expect `frame_err`=1. Then hold `rx` low for 30 cycles and release: expect no further frame until a new falling edge.
- **Low glitch of 3 cycles on idle `rx`:** expect no `rx_valid`, and `busy` returns to 0 at E+6.
- **`rx_ready`=0, two back-to-back frames 0x11 then 0x22:** expect `rx_data` to stay 0x11 and `overrun` to pulse once. After `rx_ready`=1, expect one transfer of 0x11.
- **Assert `rst`=0 mid-DATA, release, then send 0x5A:** expect all outputs at reset values during reset, and a clean reception of 0x5A afterwards.
